lwr_round_pack: RTL and testbench

- Downstream consumer of the PRF dot-product stage.
- Takes each accumulated inner product, reduces it mod q = 2^LOG_Q, and applies LWR rounding to p = 2^LOG_P.
- Packs the LOG_P-bit rounded symbols into OUT_WIDTH-bit words, then hands them to the output/serialisation logic over a valid/ready handshake.

---
 rtl/lwr_prf_pkg.sv | 29 ++
 rtl/lwr_rounder.sv | 33 +++
 rtl/lwr_round_pack.sv | 126 ++++++++++++
 tb/tb_lwr_round_pack.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lwr_prf_pkg.sv
// Shared constants and the LWR rounding function for the PRF datapath.
// The dot-product stage and the round/pack stage both import this package
// so that the modulus parameters and the rounding rule are defined once.
//   DEF_ACC_WIDTH : accumulator width of the dot product
//   DEF_LOG_Q     : log2 of modulus q
//   DEF_LOG_P     : log2 of rounding modulus p
//   DEF_OUT_WIDTH : packed output word width
//   DEF_K         : symbols per packed word
//   DEF_S         : shift that maps Z_q onto Z_p
//   lwr_round()   : mod-q reduction plus round-to-nearest onto Z_p
package lwr_prf_pkg;

    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_LOG_Q     = 12;
    localparam int DEF_LOG_P     = 4;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int DEF_K         = DEF_OUT_WIDTH / DEF_LOG_P;
    localparam int DEF_S         = DEF_LOG_Q - DEF_LOG_P;

    // Adding half a p-step before truncating gives round-to-nearest. The
    // carry out of bit LOG_Q-1 falls outside the returned field, so values
    // just below q wrap to symbol 0.
    function automatic logic [DEF_LOG_P-1:0] lwr_round(input logic [DEF_ACC_WIDTH-1:0] v);
        logic [DEF_ACC_WIDTH-1:0] sum;
        sum = v + (DEF_ACC_WIDTH'(1) << (DEF_S - 1));
        return sum[DEF_S +: DEF_LOG_P];
    endfunction

endpackage

// File: rtl/lwr_rounder.sv
// Pure combinational mod-q reduction and LWR rounding to p = 2^LOG_P.
// Ports:
//   dp_in : ACC_WIDTH-bit dot product
//   sym   : LOG_P-bit rounded symbol
// Only the low LOG_Q bits of dp_in influence the result: bits at or above
// LOG_Q never reach the extracted field, which is the mod-q reduction.
module lwr_rounder
    import lwr_prf_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LOG_Q     = DEF_LOG_Q,
    parameter int LOG_P     = DEF_LOG_P
) (
    input  logic [ACC_WIDTH-1:0] dp_in,
    output logic [LOG_P-1:0]     sym
);

    localparam int S = LOG_Q - LOG_P;

    generate
        if (ACC_WIDTH == DEF_ACC_WIDTH && LOG_Q == DEF_LOG_Q && LOG_P == DEF_LOG_P) begin : g_pkg
            // Default configuration shares the package function with other users.
            assign sym = lwr_round(dp_in);
        end else begin : g_generic
            logic [ACC_WIDTH-1:0] sum;
            logic                 unused_sum;
            assign sum        = dp_in + (ACC_WIDTH'(1) << (S - 1));
            assign sym        = sum[S +: LOG_P];
            assign unused_sum = ^sum;
        end
    endgenerate

endmodule

// File: rtl/lwr_round_pack.sv
// LWR round-and-pack stage following the PRF dot product.
// Each accepted dot product is rounded to a LOG_P-bit symbol and packed
// LSB-first into OUT_WIDTH-bit words; a word is emitted when it is full or
// when the last symbol of an evaluation arrives.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : new evaluation, discards any partial word
//   dp_in/valid/last    : dot product input stream, dp_ready is its ready
//   out_word/nelem/last : packed word, count of valid symbols, final flag
//   out_valid/out_ready : output handshake
module lwr_round_pack
    import lwr_prf_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int LOG_Q     = DEF_LOG_Q,
    parameter int LOG_P     = DEF_LOG_P,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [ACC_WIDTH-1:0]                   dp_in,
    input  logic                                   dp_valid,
    input  logic                                   dp_last,
    output logic                                   dp_ready,
    output logic [OUT_WIDTH-1:0]                   out_word,
    output logic [$clog2(OUT_WIDTH/LOG_P+1)-1:0]   out_nelem,
    output logic                                   out_valid,
    output logic                                   out_last,
    input  logic                                   out_ready
);

    localparam int K       = OUT_WIDTH / LOG_P;
    localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;
    localparam int NELEM_W = $clog2(K + 1);

    logic [LOG_P-1:0]     sym;
    logic                 xfer;
    logic                 complete;
    logic [OUT_WIDTH-1:0] pack_ins;

    logic [OUT_WIDTH-1:0] pack_q,      pack_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [OUT_WIDTH-1:0] out_word_q,  out_word_d;
    logic [NELEM_W-1:0]   out_nelem_q, out_nelem_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q,  out_last_d;

    lwr_rounder #(
        .ACC_WIDTH (ACC_WIDTH),
        .LOG_Q     (LOG_Q),
        .LOG_P     (LOG_P)
    ) u_rounder (
        .dp_in (dp_in),
        .sym   (sym)
    );

    // Accept only when the output register is free or being drained this
    // cycle, so a completing symbol always has somewhere to go.
    assign dp_ready = rst_n && !start && (!out_valid_q || out_ready);
    assign xfer     = dp_valid && dp_ready;
    assign complete = xfer && ((cnt_q == CNT_W'(K - 1)) || dp_last);

    always_comb begin
        pack_ins                        = pack_q;
        pack_ins[cnt_q*LOG_P +: LOG_P]  = sym;

        pack_d      = pack_q;
        cnt_d       = cnt_q;
        out_word_d  = out_word_q;
        out_nelem_d = out_nelem_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // Packer: start wins (no transfer can coincide with it), a completed
        // word empties the packer, otherwise the symbol is appended.
        if (start) begin
            pack_d = '0;
            cnt_d  = '0;
        end else if (complete) begin
            pack_d = '0;
            cnt_d  = '0;
        end else if (xfer) begin
            pack_d = pack_ins;
            cnt_d  = cnt_q + CNT_W'(1);
        end

        // Output register: a new word may replace one being drained in the
        // same cycle, giving back-to-back words without a bubble.
        if (complete) begin
            out_word_d  = pack_ins;
            out_nelem_d = NELEM_W'(cnt_q) + NELEM_W'(1);
            out_valid_d = 1'b1;
            out_last_d  = dp_last;
        end else if (out_valid_q && out_ready) begin
            out_word_d  = '0;
            out_nelem_d = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_q      <= '0;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_nelem_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            cnt_q       <= cnt_d;
            out_word_q  <= out_word_d;
            out_nelem_q <= out_nelem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_nelem = out_nelem_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_lwr_round_pack.sv
// Bench for lwr_round_pack with default parameters (q=4096, p=16, 8 symbols
// per 32-bit word). A cycle-level reference model built from a symbol queue
// predicts dp_ready and the output register every cycle; directed sequences
// cover the rounding boundaries and the handshake corner cases, then a
// randomized phase exercises everything together.
module tb_lwr_round_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dp_in;
    logic        dp_valid;
    logic        dp_last;
    logic        dp_ready;
    logic [31:0] out_word;
    logic [3:0]  out_nelem;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    always #5 clk = ~clk;

    lwr_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dp_in     (dp_in),
        .dp_valid  (dp_valid),
        .dp_last   (dp_last),
        .dp_ready  (dp_ready),
        .out_word  (out_word),
        .out_nelem (out_nelem),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state: symbols of the word being filled, plus the
    // expected contents of the output register.
    int          sym_q[$];
    bit          m_valid;
    bit          m_last;
    int          m_nelem;
    logic [31:0] m_word;

    // Round to nearest multiple of q/p = 256 within Z_4096, then reduce mod 16.
    function automatic int ref_round(input logic [31:0] d);
        int v;
        v = int'(d % 32'd4096);
        return ((v + 128) / 256) % 16;
    endfunction

    // One clock: drive at negedge, check dp_ready, advance model at posedge,
    // check outputs just after it, return at the next negedge.
    task automatic cycle(input bit st, input bit dv, input logic [31:0] din,
                         input bit dl, input bit ordy, output bit took);
        bit exp_rdy;
        bit loaded;
        start     = st;
        dp_valid  = dv;
        dp_in     = din;
        dp_last   = dl;
        out_ready = ordy;
        exp_rdy   = rst_n && !st && (!m_valid || ordy);
        #1;
        check("dp_ready", dp_ready, exp_rdy);
        took = dv && exp_rdy;
        @(posedge clk);
        loaded = 1'b0;
        if (!rst_n) begin
            sym_q.delete();
            m_valid = 1'b0;
            m_last  = 1'b0;
            m_nelem = 0;
            m_word  = '0;
        end else begin
            if (st) begin
                sym_q.delete();
            end else if (took) begin
                sym_q.push_back(ref_round(din));
                if (sym_q.size() == 8 || dl) begin
                    m_word = '0;
                    foreach (sym_q[i]) m_word = m_word | (32'(sym_q[i]) << (4 * i));
                    m_nelem = sym_q.size();
                    m_last  = dl;
                    m_valid = 1'b1;
                    loaded  = 1'b1;
                    sym_q.delete();
                end
            end
            if (!loaded && m_valid && ordy) m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_word", out_word, m_word);
            check("out_nelem", out_nelem, m_nelem);
            check("out_last", out_last, m_last);
        end
        if (!rst_n) begin
            check("rst_word", out_word, 0);
            check("rst_nelem", out_nelem, 0);
            check("rst_last", out_last, 0);
        end
        if (loaded)
            $display("word 0x%08h nelem %0d last %0d", m_word, m_nelem, m_last);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] v, input bit last, input bit ordy);
        bit took;
        took = 1'b0;
        for (int i = 0; i < 50 && !took; i++) cycle(1'b0, 1'b1, v, last, ordy, took);
        check("send_accepted", took, 1);
    endtask

    task automatic idle(input int n);
        bit took;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, took);
    endtask

    task automatic do_reset();
        bit took;
        rst_n = 1'b0;
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, took);
        rst_n = 1'b1;
    endtask

    logic [31:0] rnd_in [5] = '{32'h7F, 32'h80, 32'h180, 32'h12345FFF, 32'hFFFFF87F};
    int          rnd_exp[5] = '{0, 1, 2, 0, 8};

    initial begin
        bit          took;
        logic [31:0] v;
        rst_n = 1'b0; start = 1'b0; dp_in = '0; dp_valid = 1'b0;
        dp_last = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_last = 1'b0; m_nelem = 0; m_word = '0;

        do_reset();
        idle(2);

        // Rounding boundaries, one symbol per evaluation.
        for (int i = 0; i < 5; i++) begin
            send(rnd_in[i], 1'b1, 1'b1);
            v = out_word;
            check("round_sym", v[3:0], rnd_exp[i]);
            check("round_nelem", out_nelem, 1);
        end
        idle(1);

        // Full word; out_valid must rise exactly one cycle after the 8th transfer.
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) check("full_not_early", out_valid, 0);
            send(32'(i * 256), i == 8, 1'b1);
        end
        check("full_valid", out_valid, 1);
        check("full_word", out_word, 32'h87654321);
        check("full_nelem", out_nelem, 8);
        check("full_last", out_last, 1);
        idle(1);

        // Partial flush on dp_last.
        for (int i = 1; i <= 3; i++) send(32'(i * 256), i == 3, 1'b1);
        check("part_word", out_word, 32'h00000321);
        check("part_nelem", out_nelem, 3);
        check("part_last", out_last, 1);
        idle(1);

        // Backpressure: hold the first word for 5 cycles, then stream the second.
        for (int i = 1; i <= 8; i++) send(32'(i * 256), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 32'h900, 1'b0, 1'b0, took);
            check("bp_no_xfer", took, 0);
            check("bp_hold", out_word, 32'h87654321);
        end
        for (int i = 9; i <= 16; i++) send(32'(i * 256), i == 16, 1'b1);
        check("bp_word2", out_word, 32'h0FEDCBA9);
        check("bp_last2", out_last, 1);
        idle(1);

        // Start mid-word discards the partial symbols; start blocks a transfer.
        for (int i = 1; i <= 5; i++) send(32'(i * 256), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, took);
        for (int i = 1; i <= 8; i++) send(32'h100, i == 8, 1'b1);
        check("start_word", out_word, 32'h11111111);
        check("start_nelem", out_nelem, 8);
        idle(1);

        // Reset while a word is held, then while the packer holds 4 symbols.
        for (int i = 1; i <= 3; i++) send(32'(i * 256), i == 3, i != 3);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        for (int i = 1; i <= 4; i++) send(32'h300, 1'b0, 1'b1);
        do_reset();
        for (int i = 1; i <= 8; i++) send(32'(i * 256), i == 8, 1'b1);
        check("post_rst_word", out_word, 32'h87654321);
        idle(1);

        // Randomized traffic, biased towards rounding boundaries.
        for (int i = 0; i < 600; i++) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 1)
                v = {v[31:12], 4'(v[3:0]), 8'($urandom_range(0, 1) ? 8'h7F : 8'h80)};
            cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, v,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0, took);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
